// File: rtl/full_hash_des_pkg.sv
// Shared types, constants and helpers for the byte-serial DES-S1 hash.
// FULL_HASH_OVERRUN_ERR_EN (optional) is consumed by full_hash_des only.
package full_hash_des_pkg;

  typedef logic [3:0]       nibble_t;
  typedef nibble_t [7:0]    state_t;   // H0 in [3:0], H7 in [31:28]

  typedef enum logic [1:0] {ST_ABSORB, ST_FINAL, ST_DONE} fsm_e;

  localparam state_t IV = {4'h3, 4'h0, 4'hF, 4'hD, 4'h1, 4'h7, 4'hB, 4'h4};

  localparam nibble_t S1_TBL [4][16] = '{
    '{4'd14, 4'd4,  4'd13, 4'd1,  4'd2,  4'd15, 4'd11, 4'd8,
      4'd3,  4'd10, 4'd6,  4'd12, 4'd5,  4'd9,  4'd0,  4'd7},
    '{4'd0,  4'd15, 4'd7,  4'd4,  4'd14, 4'd2,  4'd13, 4'd1,
      4'd10, 4'd6,  4'd12, 4'd11, 4'd9,  4'd5,  4'd3,  4'd8},
    '{4'd4,  4'd1,  4'd14, 4'd8,  4'd13, 4'd6,  4'd2,  4'd11,
      4'd15, 4'd12, 4'd9,  4'd7,  4'd3,  4'd10, 4'd5,  4'd0},
    '{4'd15, 4'd12, 4'd8,  4'd2,  4'd4,  4'd9,  4'd1,  4'd7,
      4'd5,  4'd11, 4'd3,  4'd14, 4'd10, 4'd0,  4'd6,  4'd13}
  };

  function automatic logic [5:0] compress6(input logic [7:0] b);
    return {b[7] ^ b[1], b[3], b[2], b[5] ^ b[0], b[4], b[6]};
  endfunction

  function automatic nibble_t sbox1(input logic [5:0] m6);
    return S1_TBL[{m6[5], m6[0]}][m6[4:1]];
  endfunction

  function automatic nibble_t rotl4(input nibble_t x, input logic [1:0] n);
    case (n)
      2'd0:    return x;
      2'd1:    return {x[2:0], x[3]};
      2'd2:    return {x[1:0], x[3:2]};
      default: return {x[0], x[3:1]};
    endcase
  endfunction

endpackage

// File: rtl/full_hash_des_round.sv
// Combinational round R(H,B): 4 passes of an 8-step nibble mixing chain keyed by S1(M6).
module full_hash_des_round
  import full_hash_des_pkg::*;
(
  input  state_t     h_in,
  input  logic [7:0] b,
  output state_t     h_out
);

  nibble_t    s;
  state_t     h;
  logic [2:0] j;

  always_comb begin
    s = sbox1(compress6(b));
    h = h_in;
    j = 3'd0;
    // Steps are strictly sequential: each step sees the words updated before it.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) begin
        j    = 3'(i + 1);
        h[j] = rotl4(h[j] ^ s, 2'(i));
        h[j] = h[j] ^ h[3'(i)];
      end
    end
    h_out = h;
  end

endmodule

// File: rtl/full_hash_des.sv
// Byte-serial 32-bit hash: absorbs C_in bytes, folds in the 64-bit length, presents digest.
// Optional macro FULL_HASH_OVERRUN_ERR_EN adds the 'overrun' pulse output.
module full_hash_des
  import full_hash_des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        M_valid,
  input  logic [63:0] C_in,
  input  logic [7:0]  M,
  output logic        hash_ready,
  output logic [31:0] digest
`ifdef FULL_HASH_OVERRUN_ERR_EN
  , output logic      overrun
`endif
);

  fsm_e        st_q, st_d;
  state_t      h_q, h_d;
  logic [63:0] len_q, len_d;
  logic [63:0] cnt_q, cnt_d;
  logic        rdy_q, rdy_d;
  logic [31:0] dig_q, dig_d;

  logic        start, accept, last;
  logic [63:0] len_cur, len_eff;
  state_t      h_base, h_abs;
  state_t      fin_chain [0:8];

  assign start   = (cnt_q == 64'd0);
  assign accept  = M_valid && (st_q != ST_FINAL);
  assign len_cur = start ? C_in : len_q;
  // A zero length still absorbs one byte; finalization uses the literal value.
  assign len_eff = (len_cur == 64'd0) ? 64'd1 : len_cur;
  assign last    = accept && ((cnt_q + 64'd1) == len_eff);
  assign h_base  = start ? IV : h_q;

  full_hash_des_round u_absorb (.h_in(h_base), .b(M), .h_out(h_abs));

  // Length fold: eight rounds in one cycle, MSB byte first.
  assign fin_chain[0] = h_q;
  for (genvar g = 0; g < 8; g++) begin : g_fin
    full_hash_des_round u_fin (
      .h_in  (fin_chain[g]),
      .b     (len_q[63-8*g -: 8]),
      .h_out (fin_chain[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      st_q  <= ST_ABSORB;
      h_q   <= IV;
      len_q <= 64'd0;
      cnt_q <= 64'd0;
      rdy_q <= 1'b0;
      dig_q <= 32'd0;
    end else begin
      st_q  <= st_d;
      h_q   <= h_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
      dig_q <= dig_d;
    end
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_ABSORB, ST_DONE: begin
        if (last)        st_d = ST_FINAL;
        else if (accept) st_d = ST_ABSORB;
      end
      ST_FINAL: st_d = ST_DONE;
      default:  st_d = ST_ABSORB;
    endcase
  end

  always_comb begin
    h_d   = h_q;
    len_d = len_q;
    cnt_d = cnt_q;
    rdy_d = rdy_q;
    dig_d = dig_q;
    if (st_q == ST_FINAL) begin
      dig_d = fin_chain[8];
      rdy_d = 1'b1;
    end else if (accept) begin
      h_d   = h_abs;
      cnt_d = last ? 64'd0 : cnt_q + 64'd1;
      if (start) begin
        len_d = C_in;
        rdy_d = 1'b0;
      end
    end
  end

  assign hash_ready = rdy_q;
  assign digest     = dig_q;

`ifdef FULL_HASH_OVERRUN_ERR_EN
  logic ovr_q, ovr_d;

  assign ovr_d = M_valid && (st_q == ST_FINAL);

  always_ff @(posedge clk) begin
    if (rst_n) ovr_q <= 1'b0;
    else       ovr_q <= ovr_d;
  end

  assign overrun = ovr_q;
`endif

endmodule

// File: tb/tb_full_hash_des.sv
// Randomized self-checking bench for full_hash_des against a behavioural hash model.
module tb_full_hash_des;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        M_valid;
  logic [63:0] C_in;
  logic [7:0]  M;
  logic        hash_ready;
  logic [31:0] digest;
`ifdef FULL_HASH_OVERRUN_ERR_EN
  logic        overrun;
`endif

  full_hash_des dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .M_valid    (M_valid),
    .C_in       (C_in),
    .M          (M),
    .hash_ready (hash_ready),
    .digest     (digest)
`ifdef FULL_HASH_OVERRUN_ERR_EN
    , .overrun  (overrun)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  byte unsigned msg[$];
  logic [31:0] single_exp;

  int s1_ref [64] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
    0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
    15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rotl(input int x, input int n);
    return ((x << n) | (x >> (4 - n))) & 15;
  endfunction

  function automatic logic [31:0] ref_round(input logic [31:0] st, input int b);
    int a[8];
    int bit_[8];
    int m6, s, j;
    for (int k = 0; k < 8; k++) begin
      a[k]    = int'(st[4*k +: 4]);
      bit_[k] = (b >> k) & 1;
    end
    m6 = ((bit_[7] ^ bit_[1]) << 5) | (bit_[3] << 4) | (bit_[2] << 3) |
         ((bit_[5] ^ bit_[0]) << 2) | (bit_[4] << 1) | bit_[6];
    s = s1_ref[(((m6 >> 5) & 1) * 2 + (m6 & 1)) * 16 + ((m6 >> 1) & 15)];
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 8; i++) begin
        j    = (i + 1) % 8;
        a[j] = rotl(a[j] ^ s, i % 4);
        a[j] = a[j] ^ a[i];
      end
    for (int k = 0; k < 8; k++) st[4*k +: 4] = 4'(a[k]);
    return st;
  endfunction

  function automatic logic [31:0] ref_hash(input int n, input logic [63:0] len);
    logic [31:0] st = 32'h30FD17B4;
    for (int i = 0; i < n; i++) st = ref_round(st, int'(msg[i]));
    for (int k = 7; k >= 0; k--) st = ref_round(st, int'(len[8*k +: 8]));
    return st;
  endfunction

  // gap: 0 = back-to-back, 1 = every other cycle, 2 = random idle gaps.
  // ovr: hold M_valid high during the finalization cycle.
  task automatic send_msg(input int n, input logic [63:0] clen, input int gap, input bit ovr);
    logic [31:0] exp = ref_hash(n, clen);
    int g;
    for (int i = 0; i < n; i++) begin
      M_valid = 1'b1;
      M       = msg[i];
      C_in    = (i == 0) ? clen : {$urandom, $urandom};
      @(posedge clk); #1;
      chk("ready_low_while_absorbing", {63'd0, hash_ready}, 64'd0);
      if (i < n - 1 && gap != 0) begin
        g = (gap == 1) ? 1 : $urandom_range(0, 3);
        M_valid = 1'b0;
        M       = 8'($urandom);
        repeat (g) @(posedge clk);
        #1;
      end
    end
    M_valid = ovr;
    M       = 8'($urandom);
    @(posedge clk); #1;
    chk("ready_after_final", {63'd0, hash_ready}, 64'd1);
    chk("digest", {32'd0, digest}, {32'd0, exp});
`ifdef FULL_HASH_OVERRUN_ERR_EN
    chk("overrun_pulse", {63'd0, overrun}, {63'd0, ovr});
`endif
    M_valid = 1'b0;
    @(posedge clk); #1;
    chk("ready_hold", {63'd0, hash_ready}, 64'd1);
    chk("digest_hold", {32'd0, digest}, {32'd0, exp});
`ifdef FULL_HASH_OVERRUN_ERR_EN
    chk("overrun_clear", {63'd0, overrun}, 64'd0);
`endif
  endtask

  task automatic load_seq(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'(i));
  endtask

  initial begin
    int n;
    rst_n = 1'b1; M_valid = 1'b0; C_in = 64'd0; M = 8'd0;
    repeat (2) @(posedge clk); #1;
    chk("reset_ready", {63'd0, hash_ready}, 64'd0);
    chk("reset_digest", {32'd0, digest}, 64'd0);
    rst_n = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("idle_ready", {63'd0, hash_ready}, 64'd0);
    chk("idle_digest", {32'd0, digest}, 64'd0);

    // single zero byte
    msg.delete(); msg.push_back(8'h00);
    single_exp = ref_hash(1, 64'd1);
    send_msg(1, 64'd1, 0, 1'b0);

    // 50 bytes: alternate cycles, full throughput, restart from DONE
    load_seq(50);
    send_msg(50, 64'd50, 1, 1'b0);
    send_msg(50, 64'd50, 0, 1'b0);
    send_msg(50, 64'd50, 1, 1'b0);

    // reset mid-message, then a single-byte message
    for (int i = 0; i < 20; i++) begin
      M_valid = 1'b1; M = msg[i]; C_in = 64'd50;
      @(posedge clk); #1;
    end
    M_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    chk("midreset_ready", {63'd0, hash_ready}, 64'd0);
    chk("midreset_digest", {32'd0, digest}, 64'd0);
    msg.delete(); msg.push_back(8'h00);
    send_msg(1, 64'd1, 0, 1'b0);
    chk("midreset_single_digest", {32'd0, digest}, {32'd0, single_exp});

    // M_valid during finalization is dropped
    load_seq(5);
    send_msg(5, 64'd5, 0, 1'b1);

    // zero length absorbs one byte, folds literal zero
    msg.delete(); msg.push_back(8'($urandom));
    send_msg(1, 64'd0, 0, 1'b0);

    // random messages
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 40);
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
      send_msg(n, 64'(n), $urandom_range(0, 2), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/full_hash_des.md
Name: full_hash_des

Overview:
- Byte-serial 32-bit hash built on the DES S-box S1; sits in the security datapath between a byte source and a digest consumer.
- Absorbs a message of C_in bytes, one byte per M_valid pulse, then folds the 64-bit length into the state.
- Presents a 32-bit digest with a hash_ready flag.

Parameters:
- None. All widths are fixed by the package.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-high. The name is kept for codebase compatibility; the polarity is high.
- M_valid  in  1  qualifies M for one cycle; one byte per high cycle.
- C_in  in  64  message length in bytes; sampled on the first accepted byte of a message.
- M  in  8  message byte.
- hash_ready  out  1  digest valid.
- digest  out  32  hash result, {H7,...,H0} with H0 in bits [3:0].

Behaviour:
- State: eight 4-bit words H0..H7, a 64-bit length register, a 64-bit byte counter, FSM {ABSORB, FINAL, DONE}.
- IV: H0..H7 = 4,B,7,1,D,F,0,3.
- Reset (rst_n=1 at a rising edge):
  - H=IV, counter=0, FSM=ABSORB.
  - hash_ready=0, digest=0.
  - Reset wins over every other event, including mid-message.

Round function R(H, B) for byte B, combinational:
- Compress B to 6 bits: M6 = {B[7]^B[1], B[3], B[2], B[5]^B[0], B[4], B[6]}.
- Apply DES S1 to M6: row = {M6[5],M6[0]}, column = M6[4:1].
- For r=0..3, then i=0..7, sequentially:
  - j = (i+1) mod 8.
  - H[j] = rotl4(H[j] ^ S1(M6), i mod 4).
  - H[j] ^= H[i].

ABSORB:
- On an edge with M_valid=1:
  - If counter=0: latch C_in and load H=IV before applying R, so each new message starts fresh. Clear hash_ready.
  - H <= R(H, M); counter++.
  - When counter+1 equals the latched length, go to FINAL.
- M_valid=0: hold state.
- Latency requirement: a byte every cycle must be accepted (full throughput). M_valid every other cycle is also legal.

FINAL (exactly one cycle):
- Apply R sequentially to the 8 length bytes, MSB byte first.
- digest <= {H7..H0} of the result; hash_ready <= 1; FSM -> DONE.
- M_valid during FINAL is ignored.

DONE:
- digest and hash_ready hold.
- The next M_valid restarts the message (as counter=0 in ABSORB, from IV) and drops hash_ready on that edge.

Timing:
- Last byte accepted at edge k → hash_ready=1 after edge k+1.

Edge cases:
- C_in=0 is illegal; it is treated as 1 for counting, while the finalization uses the literal latched value.
- C_in changes mid-message are ignored.

Optional Feature:
- Macro: FULL_HASH_OVERRUN_ERR_EN.
- Defined: adds output overrun (1 bit). It is a one-cycle pulse, registered, on any edge where M_valid=1 while FSM=FINAL. Reset value 0.
- Undefined: the port is absent, and M_valid in FINAL is silently dropped.

Decomposition:
- Package full_hash_des_pkg holds:
  - IV constant array.
  - 4x16 S1 table.
  - nibble_t / state_t (8x nibble_t) typedefs.
  - FSM enum.
  - Functions compress6, sbox1, rotl4.
- One sub-module: full_hash_des_round, the combinational R(H,B). It is instantiated once for absorb and chained 8x for FINAL, or implemented as a package function.

Test Plan:
- Reset: hold rst_n=1 for 2 cycles → hash_ready=0, digest=32'h0; release, no M_valid for 10 cycles → outputs unchanged.
- Single byte: C_in=1, M=8'h00 one pulse → hash_ready=1 one edge after acceptance; digest equals the model R applied to IV with 0x00, then the 8 length bytes {0,0,0,0,0,0,0,1}.
- Full message: C_in=50, M=0..49 with M_valid high every other cycle → hash_ready=1 one edge after byte 49; digest matches the model; no hash_ready before byte 49.
- Throughput: same 50 bytes with M_valid continuously high → identical digest to the previous scenario.
- Restart: after DONE, send the same 50-byte message again → hash_ready drops on the first byte; the final digest is identical.
- Reset mid-message: assert rst_n after byte 20 of 50, then send a full C_in=1 message → digest equals the single-byte result; with FULL_HASH_OVERRUN_ERR_EN defined, M_valid in FINAL → overrun pulses 1 cycle.
